// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall/bubble control for a 5-stage pipeline.
// Forward select and first stall cycle are combinational; no flow control, counters saturate.
module fwd_hazard_unit #(
    parameter int ADDR_W         = 4,
    parameter int NUM_SRC        = 2,
    parameter int ZERO_REG_EN    = 1,
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*ADDR_W-1:0]   id_ex_src,
    input  logic [NUM_SRC-1:0]          id_ex_src_used,
    input  logic [NUM_SRC*ADDR_W-1:0]   if_id_src,
    input  logic [NUM_SRC-1:0]          if_id_src_used,
    input  logic [ADDR_W-1:0]           id_ex_rd,
    input  logic                        id_ex_regwrite,
    input  logic                        id_ex_memread,
    input  logic [ADDR_W-1:0]           ex_mem_rd,
    input  logic                        ex_mem_regwrite,
    input  logic [ADDR_W-1:0]           mem_wb_rd,
    input  logic                        mem_wb_regwrite,
    input  logic                        cnt_clr,
    output logic [2*NUM_SRC-1:0]        forward_sel,
    output logic                        stall,
    output logic                        bubble,
    output logic [CNT_W-1:0]            fwd_count,
    output logic [CNT_W-1:0]            stall_count
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // The cycle in which the hazard is detected is already the first stall cycle.
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYC - 1);

    state_t             state;
    logic [2:0]         rem;
    logic [NUM_SRC-1:0] src_hit;
    logic               hazard;
    logic               fwd_any;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [ADDR_W-1:0] ex_s;
        logic [ADDR_W-1:0] id_s;
        logic              ex_zero;
        logic              id_zero;

        assign ex_s    = id_ex_src[k*ADDR_W +: ADDR_W];
        assign id_s    = if_id_src[k*ADDR_W +: ADDR_W];
        assign ex_zero = (ZERO_REG_EN != 0) && (ex_s == '0);
        assign id_zero = (ZERO_REG_EN != 0) && (id_s == '0);

        // The younger result (EX/MEM) wins over the older one (MEM/WB).
        assign forward_sel[2*k +: 2] =
            (!id_ex_src_used[k] || ex_zero)            ? 2'b00 :
            (ex_mem_regwrite && (ex_mem_rd == ex_s))   ? 2'b10 :
            (mem_wb_regwrite && (mem_wb_rd == ex_s))   ? 2'b01 :
                                                         2'b00;

        assign src_hit[k] = if_id_src_used[k] && !id_zero && (id_s == id_ex_rd);
    end

    assign hazard  = id_ex_memread && id_ex_regwrite && (|src_hit);
    assign fwd_any = |forward_sel;
    assign stall   = (state == STALL) || hazard;
    assign bubble  = stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            rem   <= 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard && (LOAD_STALL_CYC > 1)) begin
                        state <= STALL;
                        rem   <= STALL_RELOAD;
                    end
                end
                STALL: begin
                    if (rem <= 3'd1) begin
                        state <= RUN;
                        rem   <= 3'd0;
                    end else begin
                        rem <= rem - 3'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    rem   <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            fwd_count   <= '0;
            stall_count <= '0;
        end else begin
            if (fwd_any && (fwd_count != '1)) begin
                fwd_count <= fwd_count + 1'b1;
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule
